alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execution-side consumer of the 4-bit ALU control code: takes {ctrl, src1, src2} over a valid/ready
//  handshake and returns a registered result plus flags. Optionally runs an iterative multiply.
//  Sits between the ALU controller/decode stage and writeback; it is the receiving end of ALUCtrl.
// PARAMETERS
//  DATA_W   32  operand/result width
//  CTRL_W   4   ALU control code width (fixed encoding below)
// PORTS
//  clk_i       in   1       clock, all state on rising edge
//  rst_i       in   1       synchronous reset, active-high
//  valid_i     in   1       request valid
//  ready_o     out  1       unit accepts request this cycle
//  ctrl_i      in   CTRL_W  op: ADD=0010 SUB=0110 AND=0001 OR=0000 SLT=0111 MUL=0011 NON=1111
//  src1_i      in   DATA_W  operand A
//  src2_i      in   DATA_W  operand B
//  valid_o     out  1       result valid
//  ready_i     in   1       downstream accepts result
//  result_o    out  DATA_W  registered result
//  zero_o      out  1       result_o == 0
//  overflow_o  out  1       signed overflow (ADD/SUB only, else 0)
//  illegal_o   out  1       op was NON or unsupported code; result_o = 0
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): state=IDLE, valid_o=0, result_o=0, zero_o=0, overflow_o=0, illegal_o=0,
//    mul counter=0; any multiply in flight is aborted, no result produced.
//  - Accept = valid_i & ready_o. ready_o = (state==IDLE) & (!valid_o | ready_i).
//  - Output register holds all outputs stable while valid_o & !ready_i. Drain (valid_o & ready_i)
//    and accept in same cycle allowed: new result replaces old, valid_o stays 1 (throughput 1/cycle).
//  - Drain with no accept: valid_o -> 0 next cycle; result_o/flags keep last value.
//  - Single-cycle ops: result registered 1 cycle after accept.
//    ADD/SUB: wrap modulo 2^DATA_W; overflow_o = signed overflow of the operation.
//    AND/OR: bitwise. SLT: result = {0..,1} iff signed(src1) < signed(src2) (true compare, no wrap error).
//    Any other code: result_o=0, illegal_o=1, valid_o=1 (illegal ops still complete and are consumed).
//  - zero_o computed from the value being loaded into result_o.
//  - FSM: IDLE -> (accept MUL) -> MUL_BUSY; MUL_BUSY for DATA_W cycles (shift-add, 1 bit/cycle)
//    -> MUL_DONE; MUL_DONE loads result (low DATA_W bits of product), valid_o=1 -> IDLE.
//    MUL_DONE waits (no load) if valid_o & !ready_i. Latency MUL = DATA_W+1 cycles if unstalled.
//  - ready_o=0 in MUL_BUSY/MUL_DONE; valid_i ignored there.
// CONFIGURATION
//  ALU_EXEC_MUL_EN defined: MUL (0011) executes as above, FSM includes MUL_BUSY/MUL_DONE.
//  Not defined: 0011 is illegal (result 0, illegal_o=1, 1-cycle latency); FSM reduces to IDLE only.
// STRUCTURE
//  Shared package alu_ctrl_pkg: CTRL_W, op-code constants (ADD/SUB/AND/OR/SLT/MUL/NON), FSM state
//  encoding; also used by the ALU controller so encodings cannot diverge.
//  One sub-module: alu_shift_add_mul (start/busy/done, DATA_W-cycle iterative multiplier),
//  instantiated only under ALU_EXEC_MUL_EN.
// TESTING
//  1 ADD 0x7FFFFFFF+1, ready_i=1 -> next cycle valid_o=1, result 0x80000000, overflow_o=1, zero_o=0.
//  2 SUB 5-5 then SLT -1<1 back-to-back -> results 0 (zero_o=1) then 1; one result per cycle.
//  3 ADD with ready_i=0 for 3 cycles -> result/flags stable, ready_o=0; ready_i=1 with new valid_i
//    -> old drained, new loaded same cycle.
//  4 ctrl 1111, src 0x12,0x34 -> result 0, illegal_o=1, valid_o=1.
//  5 MUL_EN: MUL 7*6 -> ready_o low, valid_o after 33 cycles, result 42; without MUL_EN -> illegal_o=1.
//  6 MUL_EN: rst_i=1 at cycle 10 of MUL -> next cycle IDLE, valid_o=0, ready_o=1, no result emitted.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encoding: op codes and exec-unit FSM state encoding.
// Used by both the ALU controller and alu_exec_unit so the encodings stay in lockstep.
package alu_ctrl_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] OP_OR  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] OP_AND = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] OP_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] OP_MUL = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] OP_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] OP_SLT = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] OP_NON = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_MUL_DONE = 2'd2
  } exec_state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W cycles per product.
// last_o flags the final iteration so the caller can advance in the same edge the product settles.
module alu_shift_add_mul #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              last_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  assign last_o    = busy_o && (cnt == CNT_W'(DATA_W-1));
  assign product_o = acc;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start_i) begin
      busy_o <= 1'b1;
      done_o <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a_i;
      mplier <= b_i;
    end else if (busy_o) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last_o) begin
        busy_o <= 1'b0;
        done_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: consumes {ctrl, src1, src2} over valid/ready, returns a registered
// result with zero/overflow/illegal flags. Define ALU_EXEC_MUL_EN to enable the iterative
// multiply (op 0011); otherwise that code is treated as illegal.
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              overflow_o,
  output logic              illegal_o
);

  localparam int MSB = DATA_W - 1;

  logic              accept;
  logic              stall;
  logic              drain;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] nxt_res;
  logic              nxt_ovf;
  logic              nxt_ill;
  logic              load;
  logic [DATA_W-1:0] load_res;
  logic              load_ovf;
  logic              load_ill;

  assign accept = valid_i & ready_o;
  assign stall  = valid_o & ~ready_i;
  assign drain  = valid_o & ready_i;
  assign sum    = src1_i + src2_i;
  assign diff   = src1_i - src2_i;

  // Single-cycle datapath; anything not decoded here returns 0 with illegal set.
  always_comb begin
    nxt_res = '0;
    nxt_ovf = 1'b0;
    nxt_ill = 1'b0;
    case (ctrl_i)
      OP_ADD: begin
        nxt_res = sum;
        nxt_ovf = (src1_i[MSB] == src2_i[MSB]) && (sum[MSB] != src1_i[MSB]);
      end
      OP_SUB: begin
        nxt_res = diff;
        nxt_ovf = (src1_i[MSB] != src2_i[MSB]) && (diff[MSB] != src1_i[MSB]);
      end
      OP_AND: nxt_res = src1_i & src2_i;
      OP_OR:  nxt_res = src1_i | src2_i;
      OP_SLT: nxt_res = DATA_W'($signed(src1_i) < $signed(src2_i));
`ifdef ALU_EXEC_MUL_EN
      OP_MUL: ; // handled by the multiplier path, never loaded from here
`endif
      default: nxt_ill = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  exec_state_t       state;
  logic              is_mul;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_last;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;
  logic              load_mul;

  assign is_mul    = (ctrl_i == OP_MUL);
  assign mul_start = accept & is_mul;
  assign ready_o   = (state == S_IDLE) & (~valid_o | ready_i);
  assign load_mul  = (state == S_MUL_DONE) & mul_done & ~stall;
  assign load      = (accept & ~is_mul) | load_mul;
  assign load_res  = load_mul ? mul_prod : nxt_res;
  assign load_ovf  = load_mul ? 1'b0 : nxt_ovf;
  assign load_ill  = load_mul ? 1'b0 : nxt_ill;

  alu_shift_add_mul #(.DATA_W(DATA_W)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .a_i       (src1_i),
    .b_i       (src2_i),
    .busy_o    (mul_busy),
    .last_o    (mul_last),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Multiply sequencing: stay busy for DATA_W iterations, then wait in DONE until the result can load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (mul_start) state <= S_MUL_BUSY;
        S_MUL_BUSY: if (mul_busy && mul_last) state <= S_MUL_DONE;
        S_MUL_DONE: if (load_mul) state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end
`else
  assign ready_o  = ~valid_o | ready_i;
  assign load     = accept;
  assign load_res = nxt_res;
  assign load_ovf = nxt_ovf;
  assign load_ill = nxt_ill;
`endif

  // Output register: load replaces (even while draining), drain alone only drops valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      overflow_o <= 1'b0;
      illegal_o  <= 1'b0;
    end else if (load) begin
      valid_o    <= 1'b1;
      result_o   <= load_res;
      zero_o     <= (load_res == '0);
      overflow_o <= load_ovf;
      illegal_o  <= load_ill;
    end else if (drain) begin
      valid_o    <= 1'b0;
    end
  end

endmodule
